// File: rtl/lock_pkg.sv
// Shared types and helpers for the keypad lock session controller.
package lock_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENTRY,
      ST_UNLOCKED,
      ST_PROG,
      ST_LOCKOUT
   } state_e;

   // Packs four digits into a code word, first digit in the MSBs.
   function automatic logic [4*DIGIT_W-1:0] pack_code4(input logic [DIGIT_W-1:0] d0,
                                                       input logic [DIGIT_W-1:0] d1,
                                                       input logic [DIGIT_W-1:0] d2,
                                                       input logic [DIGIT_W-1:0] d3);
      return {d0, d1, d2, d3};
   endfunction

   // A keypad digit is usable only if it is a BCD value.
   function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
      return d <= MAX_DIGIT;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the entry timeout, relock and lockout phases.
// done_o is high while the count sits at zero; the count never wraps.
module lock_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Reload on request, otherwise count down and hold at zero.
   always_comb begin
      // NOTE: assign the default first so every path drives cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: non-blocking assignments in clocked blocks so all flops update from pre-edge values.
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lock_controller.sv
// Keypad lock session controller: collects digit entries, checks complete codes
// against a programmable code register, counts failures, enforces lockout,
// auto-relocks and lets an unlocked user reprogram the code.
module lock_controller
   import lock_pkg::*;
#(
   parameter int CODE_LEN       = 4,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int RELOCK_CYCLES  = 500,
   parameter int ENTRY_TIMEOUT  = 200,
   parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = pack_code4(4'd4, 4'd3, 4'd2, 4'd1)
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [DIGIT_W-1:0]               digit_in,
   input  logic                             load,
   input  logic                             lock_req,
   input  logic                             prog_req,
   output logic                             unlocked,
   output logic                             locked_out,
   output logic                             fail_pulse,
   output logic                             prog_active,
   output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

   localparam int CODE_W   = CODE_LEN * DIGIT_W;
   localparam int FAIL_W   = $clog2(MAX_FAILS + 1);
   localparam int CNT_W    = $clog2(CODE_LEN + 1);
   localparam int MAX_TIME = (LOCKOUT_CYCLES > RELOCK_CYCLES)
                             ? ((LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT)
                             : ((RELOCK_CYCLES > ENTRY_TIMEOUT) ? RELOCK_CYCLES : ENTRY_TIMEOUT);
   localparam int TIMER_W  = $clog2(MAX_TIME + 1);

   state_e              state_q, state_d;
   logic [CODE_W-1:0]   buf_q, buf_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                bad_q, bad_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
   logic                fail_pulse_d;
   logic                unlocked_q, locked_out_q, fail_pulse_q, prog_active_q;

   logic                load_taken;
   logic                timer_load;
   logic [TIMER_W-1:0]  timer_val;
   logic                timer_done;

   logic [CODE_W-1:0]   buf_shift;
   logic                last_digit;
   logic                digit_ok;

   assign buf_shift  = {buf_q[CODE_W-DIGIT_W-1:0], digit_in};
   assign last_digit = (cnt_q == CNT_W'(CODE_LEN - 1));
   assign digit_ok   = digit_valid(digit_in);

   // Session FSM: next state, entry buffer, code register and fail bookkeeping.
   always_comb begin
      state_d      = state_q;
      buf_d        = buf_q;
      cnt_d        = cnt_q;
      bad_d        = bad_q;
      code_d       = code_q;
      fail_cnt_d   = fail_cnt_q;
      fail_pulse_d = 1'b0;
      load_taken   = 1'b0;

      case (state_q)
         ST_IDLE, ST_ENTRY: begin
            if (load) begin
               // IDLE always holds an empty buffer, so the first digit uses the same path.
               load_taken = 1'b1;
               buf_d      = buf_shift;
               cnt_d      = cnt_q + CNT_W'(1);
               bad_d      = bad_q | ~digit_ok;
               state_d    = ST_ENTRY;
               if (last_digit) begin
                  if (!bad_d && (buf_d == code_q)) begin
                     state_d    = ST_UNLOCKED;
                     fail_cnt_d = '0;
                  end else begin
                     fail_pulse_d = 1'b1;
                     if (fail_cnt_q != FAIL_W'(MAX_FAILS)) begin
                        fail_cnt_d = fail_cnt_q + FAIL_W'(1);
                     end
                     state_d = (fail_cnt_d == FAIL_W'(MAX_FAILS)) ? ST_LOCKOUT : ST_IDLE;
                  end
               end
            end else if ((state_q == ST_ENTRY) && timer_done) begin
               state_d = ST_IDLE;
            end
         end

         ST_UNLOCKED: begin
            if (lock_req || timer_done) begin
               state_d = ST_IDLE;
            end else if (prog_req) begin
               state_d = ST_PROG;
            end
         end

         ST_PROG: begin
            if (lock_req) begin
               state_d = ST_IDLE;
            end else if (load) begin
               load_taken = 1'b1;
               if (!digit_ok) begin
                  state_d = ST_UNLOCKED;
               end else begin
                  buf_d = buf_shift;
                  cnt_d = cnt_q + CNT_W'(1);
                  if (last_digit) begin
                     code_d  = buf_shift;
                     state_d = ST_UNLOCKED;
                  end
               end
            end else if (timer_done) begin
               state_d = ST_UNLOCKED;
            end
         end

         ST_LOCKOUT: begin
            if (timer_done) begin
               state_d    = ST_IDLE;
               fail_cnt_d = '0;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Any partial entry is discarded once we leave the collecting states.
      if ((state_d != ST_ENTRY) && (state_d != ST_PROG)) begin
         buf_d = '0;
         cnt_d = '0;
         bad_d = 1'b0;
      end
   end

   // Timer reload on every state change and every accepted digit.
   always_comb begin
      timer_load = load_taken || (state_d != state_q);
      case (state_d)
         ST_ENTRY, ST_PROG: timer_val = TIMER_W'(ENTRY_TIMEOUT - 1);
         ST_UNLOCKED:       timer_val = TIMER_W'(RELOCK_CYCLES - 1);
         ST_LOCKOUT:        timer_val = TIMER_W'(LOCKOUT_CYCLES - 1);
         default:           timer_val = '0;
      endcase
   end

   lock_timer #(
      .W (TIMER_W)
   ) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (timer_load),
      .load_val_i (timer_val),
      .done_o     (timer_done)
   );

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         buf_q         <= '0;
         cnt_q         <= '0;
         bad_q         <= 1'b0;
         // NOTE: the code register is reset on purpose so a reset always restores the factory code.
         code_q        <= DEFAULT_CODE;
         fail_cnt_q    <= '0;
         unlocked_q    <= 1'b0;
         locked_out_q  <= 1'b0;
         fail_pulse_q  <= 1'b0;
         prog_active_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         buf_q         <= buf_d;
         cnt_q         <= cnt_d;
         bad_q         <= bad_d;
         code_q        <= code_d;
         fail_cnt_q    <= fail_cnt_d;
         unlocked_q    <= (state_d == ST_UNLOCKED) || (state_d == ST_PROG);
         locked_out_q  <= (state_d == ST_LOCKOUT);
         fail_pulse_q  <= fail_pulse_d;
         prog_active_q <= (state_d == ST_PROG);
      end
   end

   assign unlocked    = unlocked_q;
   assign locked_out  = locked_out_q;
   assign fail_pulse  = fail_pulse_q;
   assign prog_active = prog_active_q;
   assign fail_count  = fail_cnt_q;

endmodule

// File: tb/tb_lock_controller.sv
// Testbench for lock_controller: directed scenarios followed by randomized
// sessions, all checked every cycle against a timestamp-based reference model.
module tb_lock_controller;

   localparam int CODE_LEN       = 4;
   localparam int MAX_FAILS      = 3;
   localparam int LOCKOUT_CYCLES = 1000;
   localparam int RELOCK_CYCLES  = 500;
   localparam int ENTRY_TIMEOUT  = 200;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] digit_in = '0;
   logic       load = 1'b0;
   logic       lock_req = 1'b0;
   logic       prog_req = 1'b0;
   logic       unlocked;
   logic       locked_out;
   logic       fail_pulse;
   logic       prog_active;
   logic [1:0] fail_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lock_controller #(
      .CODE_LEN       (CODE_LEN),
      .MAX_FAILS      (MAX_FAILS),
      .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
      .RELOCK_CYCLES  (RELOCK_CYCLES),
      .ENTRY_TIMEOUT  (ENTRY_TIMEOUT),
      .DEFAULT_CODE   (16'h4321)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .digit_in    (digit_in),
      .load        (load),
      .lock_req    (lock_req),
      .prog_req    (prog_req),
      .unlocked    (unlocked),
      .locked_out  (locked_out),
      .fail_pulse  (fail_pulse),
      .prog_active (prog_active),
      .fail_count  (fail_count)
   );

   // Reference model: a mode, a digit queue and the edge at which the current
   // timed interval started. Timeouts are measured as elapsed edges.
   typedef enum int {M_IDLE, M_ENTRY, M_OPEN, M_PROG, M_LOCK} mode_t;

   mode_t  m_mode;
   int     m_code[CODE_LEN];
   int     m_digits[$];
   int     m_fails;
   bit     m_pulse;
   longint m_now  = 0;
   longint m_mark = 0;

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_code  = '{4, 3, 2, 1};
      m_digits.delete();
      m_fails = 0;
      m_pulse = 0;
      m_mark  = m_now;
   endtask

   task automatic model_step(input bit ld, input int d, input bit lr, input bit pr);
      longint el;
      bit     ok;
      m_now++;
      el      = m_now - m_mark;
      m_pulse = 0;
      case (m_mode)
         M_IDLE, M_ENTRY: begin
            if (ld) begin
               m_digits.push_back(d);
               m_mark = m_now;
               m_mode = M_ENTRY;
               if (m_digits.size() == CODE_LEN) begin
                  ok = 1;
                  for (int i = 0; i < CODE_LEN; i++) if (m_digits[i] != m_code[i]) ok = 0;
                  m_digits.delete();
                  if (ok) begin
                     m_mode  = M_OPEN;
                     m_fails = 0;
                  end else begin
                     m_pulse = 1;
                     if (m_fails < MAX_FAILS) m_fails++;
                     m_mode = (m_fails >= MAX_FAILS) ? M_LOCK : M_IDLE;
                  end
               end
            end else if (m_mode == M_ENTRY && el >= ENTRY_TIMEOUT) begin
               m_mode = M_IDLE;
               m_digits.delete();
            end
         end
         M_OPEN: begin
            if (lr || el >= RELOCK_CYCLES) begin
               m_mode = M_IDLE;
            end else if (pr) begin
               m_mode = M_PROG;
               m_mark = m_now;
               m_digits.delete();
            end
         end
         M_PROG: begin
            if (lr) begin
               m_mode = M_IDLE;
               m_digits.delete();
            end else if (ld) begin
               m_mark = m_now;
               if (d > 9) begin
                  m_mode = M_OPEN;
                  m_digits.delete();
               end else begin
                  m_digits.push_back(d);
                  if (m_digits.size() == CODE_LEN) begin
                     for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_digits[i];
                     m_digits.delete();
                     m_mode = M_OPEN;
                  end
               end
            end else if (el >= ENTRY_TIMEOUT) begin
               m_mode = M_OPEN;
               m_mark = m_now;
               m_digits.delete();
            end
         end
         M_LOCK: begin
            if (el >= LOCKOUT_CYCLES) begin
               m_mode  = M_IDLE;
               m_fails = 0;
            end
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("unlocked",    unlocked,    (m_mode == M_OPEN) || (m_mode == M_PROG));
      check("locked_out",  locked_out,  m_mode == M_LOCK);
      check("fail_pulse",  fail_pulse,  m_pulse);
      check("prog_active", prog_active, m_mode == M_PROG);
      check("fail_count",  fail_count,  m_fails);
   endtask

   // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
   task automatic tick(input bit ld, input int d, input bit lr, input bit pr);
      logic [31:0] dv;
      dv       = d;
      load     = ld;
      digit_in = dv[3:0];
      lock_req = lr;
      prog_req = pr;
      model_step(ld, d, lr, pr);
      @(posedge clk);
      #1;
      compare_all();
      load     = 1'b0;
      lock_req = 1'b0;
      prog_req = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
   endtask

   task automatic enter(input int a, input int b, input int c, input int d);
      tick(1, a, 0, 0);
      tick(1, b, 0, 0);
      tick(1, c, 0, 0);
      tick(1, d, 0, 0);
   endtask

   // Asynchronous reset asserted mid-cycle, released away from the clock edge.
   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("rst_unlocked",    unlocked,    0);
      check("rst_locked_out",  locked_out,  0);
      check("rst_fail_pulse",  fail_pulse,  0);
      check("rst_prog_active", prog_active, 0);
      check("rst_fail_count",  fail_count,  0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      int pulses;
      int dg[CODE_LEN];
      int gap;

      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check("init_unlocked",   unlocked,    0);
      check("init_locked_out", locked_out,  0);
      check("init_fail_pulse", fail_pulse,  0);
      check("init_prog",       prog_active, 0);
      check("init_fail_count", fail_count,  0);
      reset_n = 1'b1;

      // Correct code unlocks one cycle after the last digit; relock after 500 clocks.
      enter(4, 3, 2, 1);
      check("t1_open", unlocked, 1);
      idle(RELOCK_CYCLES - 1);
      check("t1_still_open", unlocked, 1);
      idle(1);
      check("t1_relock", unlocked, 0);

      // Three mismatches lead to lockout; entry is ignored until it expires.
      pulses = 0;
      for (int k = 0; k < MAX_FAILS; k++) begin
         enter(4, 3, 2, 0);
         pulses += int'(fail_pulse);
      end
      check("t2_pulses", pulses, MAX_FAILS);
      check("t2_fail_count", fail_count, MAX_FAILS);
      check("t2_locked_out", locked_out, 1);
      for (int i = 0; i < LOCKOUT_CYCLES - 1; i++) tick((i % 5) != 0, 4 - (i % 4), 0, 0);
      check("t2_still_locked", locked_out, 1);
      tick(0, 0, 0, 0);
      check("t2_lockout_over", locked_out, 0);
      check("t2_fails_cleared", fail_count, 0);

      // Reprogram the code while unlocked, then verify old and new codes.
      enter(4, 3, 2, 1);
      tick(0, 0, 0, 1);
      check("t3_prog_active", prog_active, 1);
      enter(7, 7, 0, 5);
      check("t3_prog_done", prog_active, 0);
      check("t3_still_open", unlocked, 1);
      tick(0, 0, 1, 0);
      check("t3_locked", unlocked, 0);
      enter(4, 3, 2, 1);
      check("t3_old_code_fails", fail_pulse, 1);
      enter(7, 7, 0, 5);
      check("t3_new_code_opens", unlocked, 1);
      tick(0, 0, 1, 0);

      // Entry timeout discards a partial code without counting a failure.
      do_reset();
      tick(1, 4, 0, 0);
      tick(1, 3, 0, 0);
      idle(ENTRY_TIMEOUT);
      tick(1, 2, 0, 0);
      tick(1, 1, 0, 0);
      check("t4_no_unlock", unlocked, 0);
      idle(ENTRY_TIMEOUT);
      check("t4_no_fail", fail_count, 0);
      enter(4, 3, 2, 1);
      check("t4_unlock", unlocked, 1);
      tick(0, 0, 1, 0);

      // A digit on the expiry cycle is still accepted.
      tick(1, 4, 0, 0);
      idle(ENTRY_TIMEOUT - 1);
      tick(1, 3, 0, 0);
      tick(1, 2, 0, 0);
      tick(1, 1, 0, 0);
      check("t4_edge_unlock", unlocked, 1);
      tick(0, 0, 1, 0);

      // A non-BCD digit makes the attempt a mismatch; the pulse lasts one cycle.
      enter(12, 3, 2, 1);
      check("t5_fail_pulse", fail_pulse, 1);
      check("t5_fail_count", fail_count, 1);
      tick(0, 0, 0, 0);
      check("t5_pulse_one_cycle", fail_pulse, 0);

      // Reset in the middle of programming restores the default code.
      enter(4, 3, 2, 1);
      tick(0, 0, 0, 1);
      tick(1, 9, 0, 0);
      tick(1, 8, 0, 0);
      check("t6_in_prog", prog_active, 1);
      do_reset();
      enter(4, 3, 2, 1);
      check("t6_default_code", unlocked, 1);
      tick(0, 0, 1, 0);

      // Randomized sessions checked cycle by cycle against the model.
      for (int it = 0; it < 150; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: begin
               for (int i = 0; i < CODE_LEN; i++) dg[i] = m_code[i];
               if ($urandom_range(0, 9) < 3) dg[$urandom_range(0, CODE_LEN - 1)] = $urandom_range(0, 15);
               for (int i = 0; i < CODE_LEN; i++) begin
                  tick(1, dg[i], 0, 0);
                  gap = ($urandom_range(0, 7) == 0) ? (ENTRY_TIMEOUT - 1 + $urandom_range(0, 1))
                                                    : $urandom_range(0, 2);
                  idle(gap);
               end
            end
            3: idle($urandom_range(1, 20));
            4: tick(0, 0, 1, 0);
            5: begin
               tick(0, 0, 0, 1);
               for (int i = 0; i < CODE_LEN; i++) begin
                  tick(1, ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9), 0, 0);
                  idle($urandom_range(0, 2));
               end
            end
            6: idle($urandom_range(150, 520));
            7: begin
               for (int i = 0; i < 10; i++)
                  tick($urandom_range(0, 1) == 1, $urandom_range(0, 15),
                       $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
            end
            default: enter(m_code[0], m_code[1], m_code[2], m_code[3]);
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
